// File: rtl/udp_sched_pkg.sv
// Shared types and defaults for the UDP transmit scheduler.
// Holds the FSM state encoding, the inter-frame gap, watchdog and port-base
// defaults, and the index width used by the arbiter and the top.
package udp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int unsigned SEL_W          = 3;
    localparam int unsigned START_CYCLES   = 3;
    localparam int unsigned IFG_CYCLES_DEF = 12;
    localparam int unsigned TMO_CYCLES_DEF = 4096;
    localparam logic [15:0] PORT_BASE_DEF  = 16'd5152;

endpackage

// File: rtl/udp_tx_sched_if.sv
// Channel and packet-sender signals of the UDP transmit scheduler.
// slave  : the scheduler (takes requests/lengths/tx_done, drives grants and sender controls)
// master : the channels plus packet sender around it
interface udp_tx_sched_if #(
    parameter int unsigned N_CH = 4
) ();
    logic [N_CH-1:0]    i_req;
    logic [N_CH*16-1:0] i_len;
    logic [N_CH-1:0]    o_ack;
    logic [N_CH-1:0]    o_done;
    logic               o_tx_enable;
    logic [15:0]        o_udp_len;
    logic [15:0]        o_dst_port;
    logic [2:0]         o_sel;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_err;

    modport slave (
        input  i_req, i_len, i_tx_done,
        output o_ack, o_done, o_tx_enable, o_udp_len, o_dst_port, o_sel, o_busy, o_err
    );

    modport master (
        output i_req, i_len, i_tx_done,
        input  o_ack, o_done, o_tx_enable, o_udp_len, o_dst_port, o_sel, o_busy, o_err
    );
endinterface

// File: rtl/udp_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at last+1 (mod N_CH); returns one-hot grant, its index
// and valid when any request is present.
//   req   : request vector
//   last  : index of the previously granted channel
//   grant : one-hot winner
//   idx   : winner index
//   valid : any request present
module rr_arbiter
    import udp_sched_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);
    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // First requester found walking upward from last+1 wins.
    always_comb begin
        int unsigned k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            k = (32'(last) + off) % N_CH;
            if (!valid && req[IW'(k)]) begin
                valid          = 1'b1;
                idx            = SEL_W'(k);
                grant[IW'(k)]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/udp_tx_sched.sv
// UDP transmit scheduler: round-robin grants of N_CH channels to one packet sender.
// Per packet: GRANT (ack pulse, latch len/port/sel), START (tx_enable for 3 cycles),
// WAIT (until i_tx_done), GAP (IFG_CYCLES idle), back to IDLE.
// Ports: clk, rst_n (async active-low), bus (udp_tx_sched_if.slave) carrying
//   i_req/i_len/i_tx_done in and o_ack/o_done/o_tx_enable/o_udp_len/o_dst_port/
//   o_sel/o_busy/o_err out.
// Build option: UDP_SCHED_WATCHDOG_EN enables the WAIT timeout (TMO_CYCLES) and the
//   sticky o_err flag; without it WAIT waits indefinitely and o_err stays 0.
module udp_tx_sched
    import udp_sched_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEF,
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF,
    parameter logic [15:0] PORT_BASE  = PORT_BASE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    udp_tx_sched_if.slave bus
);
    localparam int unsigned IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned LW      = $clog2(16 * N_CH);
    localparam int unsigned CNT_MAX = (TMO_CYCLES > IFG_CYCLES) ? TMO_CYCLES : IFG_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + START_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [N_CH-1:0]    ack_q, ack_d;
    logic [N_CH-1:0]    done_q, done_d;
    logic               tx_en_q, tx_en_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        port_q, port_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [N_CH-1:0]    arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [15:0]        len_sel;
    logic               wd_expire;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req   (bus.i_req),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Length of the arbitration winner.
    always_comb begin
        len_sel = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (arb_grant[IW'(k)]) len_sel = bus.i_len[LW'(16 * k) +: 16];
        end
    end

`ifdef UDP_SCHED_WATCHDOG_EN
    assign wd_expire = (state_q == ST_WAIT) && !bus.i_tx_done &&
                       (cnt_q == CNT_W'(TMO_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (arb_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_START;
            ST_START: if (cnt_q == CNT_W'(START_CYCLES - 1)) state_d = ST_WAIT;
            ST_WAIT:  if (bus.i_tx_done || wd_expire) state_d = ST_GAP;
            ST_GAP:   if (cnt_q == CNT_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; grant fields latch on entry to GRANT.
    always_comb begin
        ack_d   = '0;
        done_d  = '0;
        sel_d   = sel_q;
        len_d   = len_q;
        port_d  = port_q;
        last_d  = last_q;
        tx_en_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
`ifdef UDP_SCHED_WATCHDOG_EN
        err_d   = err_q | wd_expire;
`else
        err_d   = 1'b0;
`endif
        cnt_d   = '0;

        if (state_q == ST_IDLE && arb_valid) begin
            ack_d  = arb_grant;
            sel_d  = arb_idx;
            len_d  = len_sel;
            port_d = PORT_BASE + 16'(arb_idx);
            last_d = arb_idx;
        end

        if (state_q == ST_WAIT && state_d == ST_GAP) done_d = N_CH'(1) << sel_q;

        // Counter restarts on every state change; WAIT only counts with the watchdog.
        if (state_d == state_q) begin
            if (state_q == ST_START || state_q == ST_GAP) cnt_d = cnt_q + CNT_W'(1);
`ifdef UDP_SCHED_WATCHDOG_EN
            if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            last_q  <= SEL_W'(N_CH - 1);
            ack_q   <= '0;
            done_q  <= '0;
            tx_en_q <= 1'b0;
            len_q   <= '0;
            port_q  <= PORT_BASE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            tx_en_q <= tx_en_d;
            len_q   <= len_d;
            port_q  <= port_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_done      = done_q;
    assign bus.o_tx_enable = tx_en_q;
    assign bus.o_udp_len   = len_q;
    assign bus.o_dst_port  = port_q;
    assign bus.o_sel       = sel_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched (N_CH=4, IFG 12, PORT_BASE 5152).
// Expected grants are queued when requests are raised and popped on each o_ack.
// With UDP_SCHED_WATCHDOG_EN defined the timeout path is exercised instead of
// the indefinite-wait path.
module tb_udp_tx_sched;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_tx_sched_if #(.N_CH(4)) bus ();

    udp_tx_sched #(.N_CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [3:0]  req_v = 4'b0;
    logic [15:0] len_v [4];
    int          en_run = 0;
    int          last_start = -1;
    int          done_timer = 0;
    int          resp_delay = 2;
    int          done_exp_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          wait_start = 0;
    int          wait_entries = 0;
    int          cur_sel = 0;
    int          ack_cyc = 0;
    int          req_cyc = 0;
    bit          done_pending = 0;
    bit          stray_done = 0;
    bit          wd_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive();
        bus.i_req = req_v;
        bus.i_len = {len_v[3], len_v[2], len_v[1], len_v[0]};
    endtask

    task automatic push(input int idx, input int len);
        exp_t e;
        e.idx = idx;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // One clock: sample outputs, model channels and sender, drive inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.i_tx_done = 1'b0;
        if (stray_done) begin
            bus.i_tx_done = 1'b1;
            stray_done = 0;
        end
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) begin
                bus.i_tx_done = 1'b1;
                done_pending = 1;
                done_exp_cyc = cyc + 1;
            end
        end
        if (bus.o_ack !== 4'b0) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(bus.o_ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_vec", 32'(bus.o_ack), 32'(1) << e.idx);
                check("ack_sel", 32'(bus.o_sel), 32'(e.idx));
                check("ack_len", 32'(bus.o_udp_len), 32'(e.len));
                check("ack_port", 32'(bus.o_dst_port), 32'(5152 + e.idx));
                req_v[e.idx] = 1'b0;
                cur_sel = e.idx;
                ack_cyc = cyc;
            end
        end
        if (bus.o_tx_enable === 1'b1) begin
            if (en_run == 0) begin
                if (last_start >= 0) check("start_spacing", 32'((cyc - last_start) >= 17), 32'd1);
                last_start = cyc;
            end
            en_run++;
        end else if (en_run != 0) begin
            check("tx_en_len", 32'(en_run), 32'd3);
            en_run = 0;
            wait_start = cyc;
            wait_entries++;
            if (resp_delay > 0) done_timer = resp_delay;
        end
        if (bus.o_done !== 4'b0) begin
            check("done_expected", 32'(done_pending), 32'd1);
            check("done_vec", 32'(bus.o_done), 32'(1) << cur_sel);
            check("done_busy", 32'(bus.o_busy), 32'd1);
            if (!wd_mode) check("done_latency", 32'(cyc), 32'(done_exp_cyc));
            done_pending = 0;
            done_cnt++;
            done_cyc = cyc;
        end
        drive();
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < max) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_wait_entry(input int max);
        int n = 0;
        int w0 = wait_entries;
        while (wait_entries == w0 && n < max) begin
            tick();
            n++;
        end
        check("wait_entry_timeout", 32'(wait_entries != w0), 32'd1);
    endtask

    task automatic run_to_idle(input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(exp_q.size() == 0 && bus.o_busy === 1'b0 && !done_pending) && n < max);
        check("idle_timeout", 32'(n < max), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},  32'(bus.o_ack), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_txen"}, 32'(bus.o_tx_enable), 32'd0);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_err"},  32'(bus.o_err), 32'd0);
        check({tag, "_sel"},  32'(bus.o_sel), 32'd0);
        check({tag, "_len"},  32'(bus.o_udp_len), 32'd0);
        check({tag, "_port"}, 32'(bus.o_dst_port), 32'd5152);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit re;
        for (int k = 0; k < 4; k++) len_v[k] = 16'd0;
        bus.i_tx_done = 1'b0;
        drive();

        // Reset state.
        repeat (3) tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // Single request on channel 2.
        len_v[2] = 16'd16;
        req_v = 4'b0100;
        push(2, 16);
        drive();
        req_cyc = cyc;
        tick();
        check("ack_latency", 32'(ack_cyc), 32'(req_cyc + 1));
        wait_done(100);
        n = 0;
        while (bus.o_busy === 1'b1 && n < 50) begin
            if (n == 3) stray_done = 1;
            tick();
            n++;
        end
        check("gap_len", 32'(n), 32'd12);
        stray_done = 1;
        tick();
        tick();
        check("idle_stray_busy", 32'(bus.o_busy), 32'd0);

        // Reset in WAIT drops the packet; sender never answers.
        resp_delay = 0;
        len_v[3] = 16'd7;
        req_v = 4'b1000;
        push(3, 7);
        drive();
        wait_wait_entry(50);
        repeat (4) tick();
        check("wait_busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        last_start = -1;
        repeat (3) tick();
        check("post_rst_busy", 32'(bus.o_busy), 32'd0);

        // All four requesting: 0,1,2,3 then 0 again after it re-requests.
        resp_delay = 1;
        len_v[0] = 16'd100;
        len_v[1] = 16'd0;
        len_v[2] = 16'hFFFF;
        len_v[3] = 16'd7;
        push(0, 100);
        push(1, 0);
        push(2, 16'hFFFF);
        push(3, 7);
        push(0, 100);
        req_v = 4'b1111;
        drive();
        n = 0;
        re = 0;
        while ((exp_q.size() != 0 || bus.o_busy === 1'b1 || done_pending) && n < 2000) begin
            tick();
            n++;
            if (!re && ack_cyc == cyc && cur_sel == 0) begin
                re = 1;
                req_v[0] = 1'b1;
                drive();
            end
        end
        check("rr_seq_timeout", 32'(n < 2000), 32'd1);

        // Long WAIT; requests raised meanwhile, channel 2 withdrawn before service.
        resp_delay = 0;
        len_v[1] = 16'd33;
        req_v = 4'b0010;
        push(1, 33);
        drive();
        wait_wait_entry(50);
        req_v = req_v | 4'b1100;
        drive();
        repeat (5) tick();
        req_v[2] = 1'b0;
        drive();
        push(3, 7);
`ifdef UDP_SCHED_WATCHDOG_EN
        wd_mode = 1;
        done_pending = 1;
        wait_done(5000);
        check("wd_time", 32'(done_cyc - wait_start), 32'd4096);
        check("wd_err", 32'(bus.o_err), 32'd1);
        wd_mode = 0;
        resp_delay = 2;
        run_to_idle(500);
        check("err_sticky", 32'(bus.o_err), 32'd1);
`else
        repeat (300) tick();
        check("nowd_busy", 32'(bus.o_busy), 32'd1);
        check("nowd_err", 32'(bus.o_err), 32'd0);
        check("nowd_no_done", 32'(done_cnt), 32'd6);
        done_timer = 1;
        wait_done(10);
        resp_delay = 2;
        run_to_idle(500);
        check("err_zero", 32'(bus.o_err), 32'd0);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
